// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch handshake between the IF stage (master) and imem (slave).
// One outstanding request; ack qualifies data_imem for the current cycle.
interface fetch_stage_if;
  logic        con_imem_req;
  logic [31:0] addr_imem;
  logic        con_imem_ack;
  logic [31:0] data_imem;

  modport master (output con_imem_req, addr_imem, input  con_imem_ack, data_imem);
  modport slave  (input  con_imem_req, addr_imem, output con_imem_ack, data_imem);
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, next-PC select, imem req/ack fetch, hold buffer, IF/ID register.
// Optional macro IF_REDIRECT_FLUSH_EN squashes the word completing alongside a redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_con_stall,
  input  logic [1:0]           i_con_jump,
  input  logic [31:0]          i_addr_jump,
  input  logic [31:0]          i_data_jr,
  input  logic                 i_con_ifbranch,
  input  logic [31:0]          i_addr_branch,
  fetch_stage_if.master        imem,
  output logic [31:0]          o_addr_pc4,
  output logic [31:0]          o_data_instr,
  output logic                 o_con_valid
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic [31:0] pend_addr;
  logic        pend_vld;
  logic        req_q;

  logic [31:0] pc_plus4;
  logic        redir_vld;
  logic [31:0] redir_addr;
  logic        fetch_ack;
  logic        complete;
  logic [31:0] next_pc;
  logic [31:0] word;
  logic        squash;

  assign pc_plus4 = pc + 32'd4;

  // Branch belongs to the older instruction, so it outranks decode's jumps.
  always_comb begin
    redir_vld  = 1'b0;
    redir_addr = '0;
    if (i_con_ifbranch) begin
      redir_vld  = 1'b1;
      redir_addr = i_addr_branch;
    end else if (i_con_jump == 2'b01) begin
      redir_vld  = 1'b1;
      redir_addr = i_addr_jump;
    end else if (i_con_jump == 2'b10) begin
      redir_vld  = 1'b1;
      redir_addr = i_data_jr;
    end
  end

  assign fetch_ack = (state == S_FETCH) && imem.con_imem_ack;
  assign complete  = (fetch_ack && !i_con_stall) || ((state == S_HOLD) && !i_con_stall);
  assign next_pc   = redir_vld ? redir_addr : (pend_vld ? pend_addr : pc_plus4);
  assign word      = (state == S_HOLD) ? hold_buf : imem.data_imem;

`ifdef IF_REDIRECT_FLUSH_EN
  assign squash = redir_vld || pend_vld;
`else
  assign squash = 1'b0;
`endif

  assign imem.con_imem_req = req_q;
  assign imem.addr_imem    = pc;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state        <= S_BOOT;
      pc           <= RESET_PC;
      hold_buf     <= '0;
      pend_addr    <= '0;
      pend_vld     <= 1'b0;
      req_q        <= 1'b0;
      o_addr_pc4   <= '0;
      o_data_instr <= NOP_INSTR;
      o_con_valid  <= 1'b0;
    end else begin
      // Redirects arriving without a completion wait here; the newest one wins.
      if (complete) begin
        pend_vld <= 1'b0;
      end else if (redir_vld) begin
        pend_vld  <= 1'b1;
        pend_addr <= redir_addr;
      end

      case (state)
        S_BOOT: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end
        S_FETCH: begin
          if (imem.con_imem_ack) begin
            if (!i_con_stall) begin
              o_addr_pc4   <= pc_plus4;
              o_data_instr <= squash ? NOP_INSTR : word;
              o_con_valid  <= !squash;
              pc           <= next_pc;
            end else begin
              hold_buf <= imem.data_imem;
              req_q    <= 1'b0;
              state    <= S_HOLD;
            end
          end else if (!i_con_stall) begin
            o_data_instr <= NOP_INSTR;
            o_con_valid  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!i_con_stall) begin
            o_addr_pc4   <= pc_plus4;
            o_data_instr <= squash ? NOP_INSTR : word;
            o_con_valid  <= !squash;
            pc           <= next_pc;
            req_q        <= 1'b1;
            state        <= S_FETCH;
          end
        end
        default: begin
          state <= S_BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
